alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Parametrised successor to the single-bit ALU source-A mux. Selects both ALU operands (A and B) from N-way packed source buses, resolves register-sourced operands against EX and MEM forwarding paths, and registers the result in a one-entry valid/ready pipeline stage. Sits between decode/register-read and the ALU in the pipelined OTTER datapath.

## Interface
- WIDTH, 32, operand width in bits
- NUM_SRC_A, 4, number of source-A candidates (index 0 = rs1 register data)
- NUM_SRC_B, 4, number of source-B candidates (index 0 = rs2 register data)
- SEL_A_W, $clog2(NUM_SRC_A) (min 1), width of sel_a
- SEL_B_W, $clog2(NUM_SRC_B) (min 1), width of sel_b

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input bundle valid
- in_ready  out  1  stage can accept
- sel_a  in  SEL_A_W  source-A select
- sel_b  in  SEL_B_W  source-B select
- src_a_bus  in  NUM_SRC_A*WIDTH  packed candidates, index i at [i*WIDTH +: WIDTH]
- src_b_bus  in  NUM_SRC_B*WIDTH  packed candidates
- rs1_addr, rs2_addr  in  5 each  register indices of slot-0 operands
- ex_fwd_en  in  1  EX stage writes a register
- ex_fwd_rd  in  5  EX destination
- ex_fwd_data  in  WIDTH  EX result
- mem_fwd_en, mem_fwd_rd, mem_fwd_data  in  1/5/WIDTH  MEM-stage equivalents
- flush  in  1  synchronous kill of held/incoming bundle
- out_valid  out  1  registered operands valid
- out_ready  in  1  ALU consumes
- src_a, src_b  out  WIDTH each  registered operands
- sel_err  out  1  registered: selected index out of range for current bundle
- fwd_hit  out  2  registered: bit0 = A forwarded, bit1 = B forwarded

## Operation
- Combinational select: operand = candidate[sel]; sel ≥ NUM_SRC → operand 0, sel_err=1.
- Forwarding applies only when sel=0. Priority: EX match > MEM match > bus value. Match = fwd_en && fwd_rd==rsX_addr && rsX_addr≠0. x0 never forwarded.
- Forwarding evaluated at accept time; later changes to fwd inputs do not alter held output.
- Pipeline register: in_ready = !out_valid || out_ready (not gated by flush).
- Accept (in_valid && in_ready && !flush): load src_a, src_b, sel_err, fwd_hit; out_valid←1.
- Drain (out_valid && out_ready, no accept): out_valid←0; data regs hold last value.
- Stall (out_valid && !out_ready): all registers hold; inputs ignored.
- flush=1: out_valid←0 next edge regardless of other inputs; incoming bundle dropped; data regs hold.
- Reset (async, any time incl. mid-stall): out_valid=0, src_a=0, src_b=0, sel_err=0, fwd_hit=0; in_ready=1 once rst_n high.

## Timing
- Latency: 1 cycle accept → out_valid.
- Throughput: 1 bundle/cycle while out_ready=1 (simultaneous drain+accept reloads, out_valid stays 1).
- in_ready combinational from out_valid/out_ready; no combinational path from in_valid to out_valid.
- Outputs stable while out_valid && !out_ready.
- Forward compare and select are single-cycle combinational; must close at core clock for WIDTH=32, NUM_SRC=4.

## Test plan
- Reset: drive rst_n=0 mid-stall with out_valid=1 → out_valid=0, src_a=src_b=0, sel_err=0, fwd_hit=0 asynchronously; in_ready=1 after release.
- Basic select: sel_a=2, src_a_bus slot2=0xDEADBEEF, sel_b=1 slot1=0x12345678, in_valid=1, out_ready=1 → next cycle out_valid=1, src_a=0xDEADBEEF, src_b=0x12345678, fwd_hit=00.
- Forward priority: sel_a=0, rs1_addr=5, ex_fwd(5,0xAAAA0000), mem_fwd(5,0xBBBB0000), bus slot0=0x1 → src_a=0xAAAA0000, fwd_hit[0]=1; EX disabled → 0xBBBB0000; rs1_addr=0 with both matching rd=0 → src_a=0x1, fwd_hit[0]=0.
- Backpressure: accept bundle X, out_ready=0 for 3 cycles while new in_valid bundles offered → in_ready=0, src_a/src_b hold X; out_ready=1 with new bundle Y → next cycle outputs Y, out_valid stays 1.
- Flush: out_valid=1, flush=1 with in_valid=1 same cycle → next cycle out_valid=0, incoming bundle not delivered.
- Out-of-range: NUM_SRC_A=3, sel_a=3 → src_a=0, sel_err=1, out_valid=1.

Source files
------------

// File: rtl/alu_operand_stage_if.sv
// Operand-stage bundle: decode-side request, forwarding taps, and registered
// operand output toward the ALU.
interface alu_operand_stage_if #(
   parameter int WIDTH     = 32,
   parameter int NUM_SRC_A = 4,
   parameter int NUM_SRC_B = 4,
   parameter int SEL_A_W   = (NUM_SRC_A > 1) ? $clog2(NUM_SRC_A) : 1,
   parameter int SEL_B_W   = (NUM_SRC_B > 1) ? $clog2(NUM_SRC_B) : 1
);
   logic                       in_valid;
   logic                       in_ready;
   logic [SEL_A_W-1:0]         sel_a;
   logic [SEL_B_W-1:0]         sel_b;
   logic [NUM_SRC_A*WIDTH-1:0] src_a_bus;
   logic [NUM_SRC_B*WIDTH-1:0] src_b_bus;
   logic [4:0]                 rs1_addr;
   logic [4:0]                 rs2_addr;
   logic                       ex_fwd_en;
   logic [4:0]                 ex_fwd_rd;
   logic [WIDTH-1:0]           ex_fwd_data;
   logic                       mem_fwd_en;
   logic [4:0]                 mem_fwd_rd;
   logic [WIDTH-1:0]           mem_fwd_data;
   logic                       flush;
   logic                       out_valid;
   logic                       out_ready;
   logic [WIDTH-1:0]           src_a;
   logic [WIDTH-1:0]           src_b;
   logic                       sel_err;
   logic [1:0]                 fwd_hit;

   modport master (
      output in_valid, sel_a, sel_b, src_a_bus, src_b_bus, rs1_addr, rs2_addr,
             ex_fwd_en, ex_fwd_rd, ex_fwd_data, mem_fwd_en, mem_fwd_rd,
             mem_fwd_data, flush, out_ready,
      input  in_ready, out_valid, src_a, src_b, sel_err, fwd_hit
   );

   modport slave (
      input  in_valid, sel_a, sel_b, src_a_bus, src_b_bus, rs1_addr, rs2_addr,
             ex_fwd_en, ex_fwd_rd, ex_fwd_data, mem_fwd_en, mem_fwd_rd,
             mem_fwd_data, flush, out_ready,
      output in_ready, out_valid, src_a, src_b, sel_err, fwd_hit
   );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand select with EX/MEM forwarding, registered in a one-entry
// valid/ready stage. Parameters must match those of the connected interface.
module alu_operand_stage #(
   parameter int WIDTH     = 32,
   parameter int NUM_SRC_A = 4,
   parameter int NUM_SRC_B = 4,
   parameter int SEL_A_W   = (NUM_SRC_A > 1) ? $clog2(NUM_SRC_A) : 1,
   parameter int SEL_B_W   = (NUM_SRC_B > 1) ? $clog2(NUM_SRC_B) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_operand_stage_if.slave bus
);

   typedef struct packed {
      logic [WIDTH-1:0] value;
      logic             err;
      logic             hit;
   } operand_t;

   // Only slot 0 carries register data, so only slot 0 is eligible for
   // forwarding; x0 is hard-wired zero and must never pick up a bypass.
   function automatic operand_t resolve(
      input logic             in_range,
      input logic             sel_is_zero,
      input logic [WIDTH-1:0] cand,
      input logic [4:0]       rs_addr,
      input logic             ex_en,
      input logic [4:0]       ex_rd,
      input logic [WIDTH-1:0] ex_data,
      input logic             mem_en,
      input logic [4:0]       mem_rd,
      input logic [WIDTH-1:0] mem_data
   );
      operand_t r;
      r.value = cand;
      r.err   = !in_range;
      r.hit   = 1'b0;
      if (in_range && sel_is_zero && (rs_addr != 5'd0)) begin
         if (ex_en && (ex_rd == rs_addr)) begin
            r.value = ex_data;
            r.hit   = 1'b1;
         end else if (mem_en && (mem_rd == rs_addr)) begin
            r.value = mem_data;
            r.hit   = 1'b1;
         end
      end
      return r;
   endfunction

   logic [WIDTH-1:0] cand_a;
   logic [WIDTH-1:0] cand_b;
   logic             in_range_a;
   logic             in_range_b;
   operand_t         op_a;
   operand_t         op_b;
   logic             accept;

   logic             out_valid_q;
   logic [WIDTH-1:0] src_a_q;
   logic [WIDTH-1:0] src_b_q;
   logic             sel_err_q;
   logic [1:0]       fwd_hit_q;

   always_comb begin
      // NOTE: every output of this block is defaulted first so that a select
      // value matching no candidate yields 0 instead of inferring a latch.
      cand_a     = '0;
      cand_b     = '0;
      in_range_a = 1'b0;
      in_range_b = 1'b0;
      for (int i = 0; i < NUM_SRC_A; i++) begin
         if (bus.sel_a == SEL_A_W'(i)) begin
            cand_a     = bus.src_a_bus[i*WIDTH +: WIDTH];
            in_range_a = 1'b1;
         end
      end
      for (int i = 0; i < NUM_SRC_B; i++) begin
         if (bus.sel_b == SEL_B_W'(i)) begin
            cand_b     = bus.src_b_bus[i*WIDTH +: WIDTH];
            in_range_b = 1'b1;
         end
      end
   end

   assign op_a = resolve(in_range_a, bus.sel_a == '0, cand_a, bus.rs1_addr,
                         bus.ex_fwd_en, bus.ex_fwd_rd, bus.ex_fwd_data,
                         bus.mem_fwd_en, bus.mem_fwd_rd, bus.mem_fwd_data);
   assign op_b = resolve(in_range_b, bus.sel_b == '0, cand_b, bus.rs2_addr,
                         bus.ex_fwd_en, bus.ex_fwd_rd, bus.ex_fwd_data,
                         bus.mem_fwd_en, bus.mem_fwd_rd, bus.mem_fwd_data);

   // in_ready deliberately ignores flush so upstream sees a stable handshake.
   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         src_a_q     <= '0;
         src_b_q     <= '0;
         sel_err_q   <= 1'b0;
         fwd_hit_q   <= 2'b00;
      end else begin
         if (bus.flush) begin
            out_valid_q <= 1'b0;
         end else if (accept) begin
            out_valid_q <= 1'b1;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

         if (accept) begin
            src_a_q   <= op_a.value;
            src_b_q   <= op_b.value;
            sel_err_q <= op_a.err | op_b.err;
            fwd_hit_q <= {op_b.hit, op_a.hit};
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.src_a     = src_a_q;
   assign bus.src_b     = src_b_q;
   assign bus.sel_err   = sel_err_q;
   assign bus.fwd_hit   = fwd_hit_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed scenarios plus random
// traffic, with expected operands computed from the select/forwarding rules.
module tb_alu_operand_stage;
   localparam int W   = 32;
   localparam int NA  = 3;
   localparam int NB  = 5;
   localparam int SAW = 2;
   localparam int SBW = 3;

   typedef struct {
      logic           in_valid;
      logic           out_ready;
      logic           flush;
      logic [SAW-1:0] sel_a;
      logic [SBW-1:0] sel_b;
      logic [W-1:0]   a_bus [NA];
      logic [W-1:0]   b_bus [NB];
      logic [4:0]     rs1;
      logic [4:0]     rs2;
      logic           ex_en;
      logic [4:0]     ex_rd;
      logic [W-1:0]   ex_data;
      logic           mem_en;
      logic [4:0]     mem_rd;
      logic [W-1:0]   mem_data;
   } stim_t;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         err;
      logic [1:0]   hit;
   } exp_t;

   logic   clk;
   logic   rst_n;
   int     n_checks = 0;
   int     n_fail   = 0;
   exp_t   exp_q[$];
   logic   acc_now  = 1'b0;

   alu_operand_stage_if #(.WIDTH(W), .NUM_SRC_A(NA), .NUM_SRC_B(NB)) bus_if ();

   alu_operand_stage #(.WIDTH(W), .NUM_SRC_A(NA), .NUM_SRC_B(NB)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic stim_t idle_stim();
      stim_t s;
      s.in_valid = 1'b0; s.out_ready = 1'b1; s.flush = 1'b0;
      s.sel_a = '0; s.sel_b = '0;
      for (int i = 0; i < NA; i++) s.a_bus[i] = 32'hA000_0000 + W'(i);
      for (int i = 0; i < NB; i++) s.b_bus[i] = 32'hB000_0000 + W'(i);
      s.rs1 = '0; s.rs2 = '0;
      s.ex_en = 1'b0; s.ex_rd = '0; s.ex_data = '0;
      s.mem_en = 1'b0; s.mem_rd = '0; s.mem_data = '0;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.in_valid  = ($urandom_range(0, 9) < 7);
      s.out_ready = ($urandom_range(0, 9) < 6);
      s.flush     = ($urandom_range(0, 9) == 0);
      s.sel_a     = ($urandom_range(0, 2) == 0) ? '0 : SAW'($urandom_range(0, 3));
      s.sel_b     = ($urandom_range(0, 2) == 0) ? '0 : SBW'($urandom_range(0, 7));
      for (int i = 0; i < NA; i++) s.a_bus[i] = $urandom;
      for (int i = 0; i < NB; i++) s.b_bus[i] = $urandom;
      s.rs1      = 5'($urandom_range(0, 3));
      s.rs2      = 5'($urandom_range(0, 3));
      s.ex_en    = 1'($urandom_range(0, 1));
      s.ex_rd    = 5'($urandom_range(0, 3));
      s.ex_data  = $urandom;
      s.mem_en   = 1'($urandom_range(0, 1));
      s.mem_rd   = 5'($urandom_range(0, 3));
      s.mem_data = $urandom;
      return s;
   endfunction

   // Reference rules: out-of-range select gives 0 plus an error; slot 0 takes
   // the youngest matching producer (EX before MEM), never for register x0.
   function automatic void ref_operand(input int sel, input int n, input logic [W-1:0] slot,
                                       input logic [4:0] rs, input stim_t s,
                                       output logic [W-1:0] v, output logic err,
                                       output logic hit);
      err = (sel >= n);
      hit = 1'b0;
      v   = err ? '0 : slot;
      if (!err && sel == 0 && rs != 0) begin
         if (s.ex_en && s.ex_rd == rs) begin
            v = s.ex_data; hit = 1'b1;
         end else if (s.mem_en && s.mem_rd == rs) begin
            v = s.mem_data; hit = 1'b1;
         end
      end
   endfunction

   function automatic exp_t model(input stim_t s);
      exp_t         e;
      int           sa = int'(s.sel_a);
      int           sb = int'(s.sel_b);
      logic [W-1:0] slot_a = '0;
      logic [W-1:0] slot_b = '0;
      logic         ea, eb, ha, hb;
      if (sa < NA) slot_a = s.a_bus[sa];
      if (sb < NB) slot_b = s.b_bus[sb];
      ref_operand(sa, NA, slot_a, s.rs1, s, e.a, ea, ha);
      ref_operand(sb, NB, slot_b, s.rs2, s, e.b, eb, hb);
      e.err = ea | eb;
      e.hit = {hb, ha};
      return e;
   endfunction

   task automatic apply(input stim_t s);
      bus_if.in_valid  = s.in_valid;
      bus_if.out_ready = s.out_ready;
      bus_if.flush     = s.flush;
      bus_if.sel_a     = s.sel_a;
      bus_if.sel_b     = s.sel_b;
      for (int i = 0; i < NA; i++) bus_if.src_a_bus[i*W +: W] = s.a_bus[i];
      for (int i = 0; i < NB; i++) bus_if.src_b_bus[i*W +: W] = s.b_bus[i];
      bus_if.rs1_addr     = s.rs1;
      bus_if.rs2_addr     = s.rs2;
      bus_if.ex_fwd_en    = s.ex_en;
      bus_if.ex_fwd_rd    = s.ex_rd;
      bus_if.ex_fwd_data  = s.ex_data;
      bus_if.mem_fwd_en   = s.mem_en;
      bus_if.mem_fwd_rd   = s.mem_rd;
      bus_if.mem_fwd_data = s.mem_data;
   endtask

   // One cycle of stimulus; the queue holds exactly the bundle the stage owns.
   task automatic step(input stim_t s);
      logic exp_ready;
      @(posedge clk);
      #1;
      apply(s);
      #1;
      exp_ready = (exp_q.size() == 0) || s.out_ready;
      check("in_ready", 64'(bus_if.in_ready), 64'(exp_ready));
      if (s.in_valid && exp_ready && !s.flush) begin
         exp_q.push_back(model(s));
         acc_now = 1'b1;
      end else begin
         acc_now = 1'b0;
      end
   endtask

   initial begin : monitor
      int   held;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            held = exp_q.size() - int'(acc_now);
            check("out_valid", 64'(bus_if.out_valid), 64'(held > 0));
            if (held > 0 && bus_if.out_ready) begin
               e = exp_q.pop_front();
               check("sb_src_a", 64'(bus_if.src_a), 64'(e.a));
               check("sb_src_b", 64'(bus_if.src_b), 64'(e.b));
               check("sb_sel_err", 64'(bus_if.sel_err), 64'(e.err));
               check("sb_fwd_hit", 64'(bus_if.fwd_hit), 64'(e.hit));
            end else if (held > 0 && bus_if.flush) begin
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin : main
      stim_t idle, x, y, z, w, f, g, h;
      idle  = idle_stim();
      rst_n = 1'b1;
      apply(idle);
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 64'(bus_if.out_valid), 64'(0));
      check("rst_src_a", 64'(bus_if.src_a), 64'(0));
      check("rst_fwd_hit", 64'(bus_if.fwd_hit), 64'(0));
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1 check("rst_in_ready", 64'(bus_if.in_ready), 64'(1));

      // Basic select.
      x = idle; x.in_valid = 1'b1;
      x.sel_a = 2'd2; x.a_bus[2] = 32'hDEAD_BEEF;
      x.sel_b = 3'd1; x.b_bus[1] = 32'h1234_5678;
      step(x);
      step(idle);
      check("basic_valid", 64'(bus_if.out_valid), 64'(1));
      check("basic_src_a", 64'(bus_if.src_a), 64'h0000_0000_DEAD_BEEF);
      check("basic_src_b", 64'(bus_if.src_b), 64'h0000_0000_1234_5678);
      check("basic_fwd_hit", 64'(bus_if.fwd_hit), 64'(0));
      check("basic_sel_err", 64'(bus_if.sel_err), 64'(0));

      // Forwarding priority.
      f = idle; f.in_valid = 1'b1; f.sel_a = '0; f.rs1 = 5'd5; f.a_bus[0] = 32'h1;
      f.ex_en = 1'b1; f.ex_rd = 5'd5; f.ex_data = 32'hAAAA_0000;
      f.mem_en = 1'b1; f.mem_rd = 5'd5; f.mem_data = 32'hBBBB_0000;
      g = f; g.ex_en = 1'b0; g.rs2 = 5'd5;
      h = f; h.rs1 = 5'd0; h.ex_rd = 5'd0; h.mem_rd = 5'd0;
      step(f);
      step(g);
      check("fwd_ex_a", 64'(bus_if.src_a), 64'h0000_0000_AAAA_0000);
      check("fwd_ex_hit", 64'(bus_if.fwd_hit), 64'(2'b01));
      step(h);
      check("fwd_mem_a", 64'(bus_if.src_a), 64'h0000_0000_BBBB_0000);
      check("fwd_mem_b", 64'(bus_if.src_b), 64'h0000_0000_BBBB_0000);
      check("fwd_mem_hit", 64'(bus_if.fwd_hit), 64'(2'b11));
      step(idle);
      check("fwd_x0_a", 64'(bus_if.src_a), 64'h1);
      check("fwd_x0_hit", 64'(bus_if.fwd_hit), 64'(0));

      // Backpressure: held bundle survives three stalled cycles.
      x = idle; x.in_valid = 1'b1;
      x.sel_a = 2'd1; x.a_bus[1] = 32'h1111_1111;
      x.sel_b = 3'd2; x.b_bus[2] = 32'h2222_2222;
      z = x; z.a_bus[1] = 32'h3333_3333; z.out_ready = 1'b0;
      z.ex_en = 1'b1; z.ex_rd = 5'd1;
      step(x);
      for (int i = 0; i < 3; i++) begin
         step(z);
         check("bp_in_ready", 64'(bus_if.in_ready), 64'(0));
         check("bp_hold_a", 64'(bus_if.src_a), 64'h0000_0000_1111_1111);
         check("bp_hold_b", 64'(bus_if.src_b), 64'h0000_0000_2222_2222);
      end
      y = x; y.a_bus[1] = 32'h4444_4444; y.b_bus[2] = 32'h5555_5555;
      step(y);
      step(idle);
      check("bp_reload_valid", 64'(bus_if.out_valid), 64'(1));
      check("bp_reload_a", 64'(bus_if.src_a), 64'h0000_0000_4444_4444);
      check("bp_reload_b", 64'(bus_if.src_b), 64'h0000_0000_5555_5555);

      // Flush kills both the held and the incoming bundle.
      x = idle; x.in_valid = 1'b1; x.sel_a = 2'd1; x.a_bus[1] = 32'h6666_6666;
      w = x; w.a_bus[1] = 32'h7777_7777; w.flush = 1'b1; w.out_ready = 1'b0;
      y = idle; y.out_ready = 1'b0;
      step(x);
      step(w);
      check("flush_pre_valid", 64'(bus_if.out_valid), 64'(1));
      step(y);
      check("flush_valid", 64'(bus_if.out_valid), 64'(0));
      step(idle);
      check("flush_dropped", 64'(bus_if.out_valid), 64'(0));

      // Out-of-range selects on both operands.
      x = idle; x.in_valid = 1'b1; x.sel_a = 2'd3; x.sel_b = 3'd6;
      step(x);
      step(idle);
      check("oor_valid", 64'(bus_if.out_valid), 64'(1));
      check("oor_src_a", 64'(bus_if.src_a), 64'(0));
      check("oor_src_b", 64'(bus_if.src_b), 64'(0));
      check("oor_sel_err", 64'(bus_if.sel_err), 64'(1));

      // Asynchronous reset while stalled with a valid bundle.
      x = idle; x.in_valid = 1'b1; x.sel_a = 2'd2; x.a_bus[2] = 32'hCAFE_F00D;
      x.sel_b = 3'd0; x.rs2 = 5'd3; x.ex_en = 1'b1; x.ex_rd = 5'd3; x.ex_data = 32'h55;
      y = idle; y.out_ready = 1'b0;
      step(x);
      step(y);
      check("stall_pre_rst", 64'(bus_if.out_valid), 64'(1));
      #1;
      rst_n = 1'b0;
      apply(idle);
      exp_q.delete();
      acc_now = 1'b0;
      #1;
      check("mid_rst_valid", 64'(bus_if.out_valid), 64'(0));
      check("mid_rst_src_a", 64'(bus_if.src_a), 64'(0));
      check("mid_rst_src_b", 64'(bus_if.src_b), 64'(0));
      check("mid_rst_sel_err", 64'(bus_if.sel_err), 64'(0));
      check("mid_rst_fwd_hit", 64'(bus_if.fwd_hit), 64'(0));
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1 check("post_rst_in_ready", 64'(bus_if.in_ready), 64'(1));

      for (int i = 0; i < 2000; i++) step(rand_stim());
      for (int i = 0; i < 4; i++) step(idle);
      @(negedge clk);
      #1 check("drained", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
